// File: rtl/sram_arbiter.sv
// Two-port (fetch A / load-store B) arbiter in front of a single-port synchronous SRAM.
// Default build: round-robin with burst limit MAX_BURST; define SRAM_ARB_BPRIO_EN for strict B priority.
module sram_arbiter #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req_valid,
  output logic              a_req_ready,
  input  logic [ADDR_W-1:0] a_req_addr,
  output logic              a_rsp_valid,
  output logic [DATA_W-1:0] a_rsp_data,
  input  logic              b_req_valid,
  output logic              b_req_ready,
  input  logic              b_req_we,
  input  logic [ADDR_W-1:0] b_req_addr,
  input  logic [DATA_W-1:0] b_req_wdata,
  output logic              b_rsp_valid,
  output logic [DATA_W-1:0] b_rsp_data,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [ADDR_W-1:0] mem_rd_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {OWN_A = 1'b0, OWN_B = 1'b1} own_e;

  localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

  own_e        state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        grant_a, grant_b;
  logic        a_vld_p1, b_vld_p1;
  logic [ADDR_W-1:0] win_addr;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= OWN_A;
      cnt      <= 4'd0;
      a_vld_p1 <= 1'b0;
      b_vld_p1 <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      a_vld_p1 <= grant_a;
      b_vld_p1 <= grant_b & ~b_req_we;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
`ifdef SRAM_ARB_BPRIO_EN
    if (grant_b)      state_nxt = OWN_B;
    else if (grant_a) state_nxt = OWN_A;
`else
    if (grant_a) begin
      if (state == OWN_A) cnt_nxt = sat_inc(cnt);
      else begin
        state_nxt = OWN_A;
        cnt_nxt   = 4'd1;
      end
    end else if (grant_b) begin
      if (state == OWN_B) cnt_nxt = sat_inc(cnt);
      else begin
        state_nxt = OWN_B;
        cnt_nxt   = 4'd1;
      end
    end
`endif
  end

  // Grant is gated by rst so nothing reaches the SRAM while reset is held.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!rst) begin
`ifdef SRAM_ARB_BPRIO_EN
      if (b_req_valid)      grant_b = 1'b1;
      else if (a_req_valid) grant_a = 1'b1;
`else
      if (state == OWN_A) begin
        if (a_req_valid && (!b_req_valid || cnt < BURST_LIM)) grant_a = 1'b1;
        else if (b_req_valid)                                 grant_b = 1'b1;
      end else begin
        if (b_req_valid && (!a_req_valid || cnt < BURST_LIM)) grant_b = 1'b1;
        else if (a_req_valid)                                 grant_a = 1'b1;
      end
`endif
    end
  end

  assign win_addr    = grant_a ? a_req_addr : (grant_b ? b_req_addr : '0);
  assign a_req_ready = grant_a;
  assign b_req_ready = grant_b;
  assign mem_cs      = grant_a | grant_b;
  assign mem_we      = grant_b & b_req_we;
  assign mem_wr_addr = win_addr;
  assign mem_rd_addr = win_addr;
  assign mem_wdata   = mem_cs ? b_req_wdata : '0;

  // Stage p1: SRAM read data returns one cycle after the accept.
  assign a_rsp_valid = a_vld_p1;
  assign b_rsp_valid = b_vld_p1;
  assign a_rsp_data  = mem_rdata;
  assign b_rsp_data  = mem_rdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: random and directed traffic against a behavioural model.
module tb_sram_arbiter;

  localparam int ADDR_W    = 12;
  localparam int DATA_W    = 16;
  localparam int MAX_BURST = 4;
  localparam int DEPTH     = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              a_req_valid = 1'b0, a_req_ready;
  logic [ADDR_W-1:0] a_req_addr = '0;
  logic              a_rsp_valid;
  logic [DATA_W-1:0] a_rsp_data;
  logic              b_req_valid = 1'b0, b_req_ready;
  logic              b_req_we = 1'b0;
  logic [ADDR_W-1:0] b_req_addr = '0;
  logic [DATA_W-1:0] b_req_wdata = '0;
  logic              b_rsp_valid;
  logic [DATA_W-1:0] b_rsp_data;
  logic              mem_cs, mem_we;
  logic [ADDR_W-1:0] mem_wr_addr, mem_rd_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;

  sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_addr(a_req_addr),
    .a_rsp_valid(a_rsp_valid), .a_rsp_data(a_rsp_data),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we),
    .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata),
    .b_rsp_valid(b_rsp_valid), .b_rsp_data(b_rsp_data),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_wr_addr(mem_wr_addr), .mem_rd_addr(mem_rd_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] init_val(input int i);
    return (i == 'h010) ? 16'hBEEF : 16'(i * 16'h9E37 + 16'h1234);
  endfunction

  // Behavioural synchronous SRAM attached to the arbiter
  logic             mem_init = 1'b1;
  logic [DATA_W-1:0] sram [0:DEPTH-1];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < DEPTH; i++) sram[i] <= init_val(i);
    end else if (mem_cs) begin
      if (mem_we) sram[mem_wr_addr] <= mem_wdata;
      else        mem_rdata <= sram[mem_rd_addr];
    end
  end

  typedef struct {
    logic              ga, gb, we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              arsp, brsp;
  } rec_t;

  rec_t              gq[$];
  logic [DATA_W-1:0] a_q[$], b_q[$];
  logic [DATA_W-1:0] ref_mem [0:DEPTH-1];
  logic              owner_is_b;
  int                run;
  logic              prev_ar, prev_br;
  int                checks = 0;
  int                failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus: drive inputs, predict the cycle, queue expectations.
  task automatic cycle(input logic av, input logic [ADDR_W-1:0] aa, input logic bv,
                       input logic bwe, input logic [ADDR_W-1:0] ba, input logic [DATA_W-1:0] bd);
    rec_t r;
    logic ga, gb;
    @(posedge clk); #1;
    rst = 1'b0;
    a_req_valid = av; a_req_addr = aa;
    b_req_valid = bv; b_req_we = bwe; b_req_addr = ba; b_req_wdata = bd;
    ga = 1'b0; gb = 1'b0;
`ifdef SRAM_ARB_BPRIO_EN
    gb = bv;
    ga = av && !bv;
`else
    if (av || bv) begin
      if (!owner_is_b) begin
        if (av && (!bv || run < MAX_BURST)) ga = 1'b1; else gb = 1'b1;
      end else begin
        if (bv && (!av || run < MAX_BURST)) gb = 1'b1; else ga = 1'b1;
      end
    end
`endif
    if (ga || gb) begin
      if (ga == !owner_is_b) run++;
      else begin
        owner_is_b = gb;
        run = 1;
      end
    end
    r.ga = ga; r.gb = gb; r.we = gb && bwe;
    r.addr  = ga ? aa : (gb ? ba : '0);
    r.wdata = (ga || gb) ? bd : '0;
    r.arsp = prev_ar; r.brsp = prev_br;
    if (ga) a_q.push_back(ref_mem[aa]);
    if (gb && bwe)  ref_mem[ba] = bd;
    if (gb && !bwe) b_q.push_back(ref_mem[ba]);
    prev_ar = ga;
    prev_br = gb && !bwe;
    gq.push_back(r);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  // Asserts rst just after an edge; requests stay valid to show they are ignored.
  task automatic do_reset(input int n);
    rec_t z;
    z = '{ga: 1'b0, gb: 1'b0, we: 1'b0, addr: '0, wdata: '0, arsp: 1'b0, brsp: 1'b0};
    @(posedge clk); #1;
    rst = 1'b1;
    a_req_valid = 1'b1; b_req_valid = 1'b1; b_req_we = 1'b0;
    a_q.delete(); b_q.delete();
    owner_is_b = 1'b0; run = 0; prev_ar = 1'b0; prev_br = 1'b0;
    gq.push_back(z);
    repeat (n - 1) begin
      @(posedge clk); #1;
      gq.push_back(z);
    end
  endtask

  rec_t mr;
  always @(negedge clk) begin
    if (gq.size() > 0) begin
      mr = gq.pop_front();
      chk("a_req_ready", 32'(a_req_ready), 32'(mr.ga));
      chk("b_req_ready", 32'(b_req_ready), 32'(mr.gb));
      chk("mem_cs", 32'(mem_cs), 32'(mr.ga | mr.gb));
      chk("mem_we", 32'(mem_we), 32'(mr.we));
      chk("mem_rd_addr", 32'(mem_rd_addr), 32'(mr.addr));
      chk("mem_wr_addr", 32'(mem_wr_addr), 32'(mr.addr));
      chk("mem_wdata", 32'(mem_wdata), 32'(mr.wdata));
      chk("a_rsp_valid", 32'(a_rsp_valid), 32'(mr.arsp));
      chk("b_rsp_valid", 32'(b_rsp_valid), 32'(mr.brsp));
      if (a_rsp_valid) begin
        if (a_q.size() > 0) chk("a_rsp_data", 32'(a_rsp_data), 32'(a_q.pop_front()));
        else chk("a_rsp_unexpected", 32'd1, 32'd0);
      end
      if (b_rsp_valid) begin
        if (b_q.size() > 0) chk("b_rsp_data", 32'(b_rsp_data), 32'(b_q.pop_front()));
        else chk("b_rsp_unexpected", 32'd1, 32'd0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
    owner_is_b = 1'b0; run = 0; prev_ar = 1'b0; prev_br = 1'b0;
    repeat (2) @(posedge clk);
    mem_init = 1'b0;
    do_reset(2);
    idle(1);
    // Fetch read of pre-loaded word
    cycle(1'b1, 12'h010, 1'b0, 1'b0, '0, '0);
    idle(1);
    // Store then immediate load of the same address
    cycle(1'b0, '0, 1'b1, 1'b1, 12'h3FF, 16'hA5A5);
    cycle(1'b0, '0, 1'b1, 1'b0, 12'h3FF, '0);
    idle(2);
    // Continuous contention from a fresh reset
    do_reset(1);
    for (int i = 0; i < 12; i++)
      cycle(1'b1, 12'(i), 1'b1, 1'b0, 12'(16 + i), '0);
    for (int i = 0; i < 5; i++)
      cycle(1'b0, '0, 1'b1, 1'b0, 12'(32 + i), '0);
    // Priority window: both valid for 10 cycles, then B drops
    for (int i = 0; i < 10; i++)
      cycle(1'b1, 12'(i), 1'b1, 1'b1, 12'(40 + i), 16'(i * 3 + 1));
    cycle(1'b1, 12'h005, 1'b0, 1'b0, '0, '0);
    idle(1);
    // Read accepted, reset lands in the following cycle
    cycle(1'b1, 12'h010, 1'b0, 1'b0, '0, '0);
    do_reset(2);
    cycle(1'b1, 12'h001, 1'b1, 1'b0, 12'h002, '0);
    idle(1);
    // Random traffic over a small address window to force hazards
    for (int i = 0; i < 600; i++)
      cycle($urandom_range(0, 3) != 0, 12'($urandom_range(0, 15)),
            $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
            12'($urandom_range(0, 15)), 16'($urandom));
    idle(3);
    @(negedge clk);
    @(negedge clk);
    chk("a_q_drained", 32'(a_q.size()), 32'd0);
    chk("b_q_drained", 32'(b_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12, SHALL set the address width of the requester and memory ports.
REQ-002 Parameter DATA_W, default 16, SHALL set the data width of the requester and memory ports.
REQ-003 Parameter MAX_BURST, default 4, range 1..15, SHALL set the maximum consecutive accepts per owner while the other port waits.
REQ-004 clk  in  1  sole clock; all state changes on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 a_req_valid  in  1  port A (fetch, read-only) request valid.
REQ-007 a_req_ready  out  1  port A request accepted this cycle.
REQ-008 a_req_addr  in  ADDR_W  port A read address.
REQ-009 a_rsp_valid  out  1  port A read data valid, 1-cycle pulse.
REQ-010 a_rsp_data  out  DATA_W  port A read data.
REQ-011 b_req_valid  in  1  port B (load/store) request valid.
REQ-012 b_req_ready  out  1  port B request accepted this cycle.
REQ-013 b_req_we  in  1  port B write (1) / read (0).
REQ-014 b_req_addr  in  ADDR_W  port B address.
REQ-015 b_req_wdata  in  DATA_W  port B write data.
REQ-016 b_rsp_valid  out  1  port B read data valid, 1-cycle pulse; never pulses for writes.
REQ-017 b_rsp_data  out  DATA_W  port B read data.
REQ-018 mem_cs, mem_we  out  1 each  SRAM chip select and write enable, active-high.
REQ-019 mem_wr_addr, mem_rd_addr  out  ADDR_W each  SRAM write/read addresses.
REQ-020 mem_wdata  out  DATA_W; mem_rdata  in  DATA_W  SRAM write data / read data (valid cycle after cs).

Function
REQ-021 Accept = req_valid && req_ready; at most one port SHALL be accepted per cycle; ready SHALL be 0 on a port whose valid is 0.
REQ-022 Ready and all mem_* outputs SHALL be combinational from current valids and registered state; mem_cs SHALL be 1 exactly in accept cycles.
REQ-023 Accept cycle: mem_rd_addr = mem_wr_addr = winner address; mem_we = 1 only for accepted B write; mem_wdata = b_req_wdata; when mem_cs = 0 all mem_* SHALL be 0.
REQ-024 FSM states OWN_A, OWN_B with 4-bit burst counter cnt.
REQ-025 In OWN_X: if X valid and (other not valid or cnt < MAX_BURST) grant X, cnt <= min(cnt+1, 15).
REQ-026 In OWN_X: else if other valid, grant other, state <= OWN_other, cnt <= 1.
REQ-027 Neither valid: no grant, state and cnt hold.
REQ-028 Read accepted in cycle N SHALL give rsp_valid = 1 on that port in N+1 only, rsp_data = mem_rdata; responses SHALL not be back-pressured.
REQ-029 a_rsp_data and b_rsp_data SHALL equal mem_rdata in all cycles; only rsp_valid qualifies.
REQ-030 Write in N followed by read of same address in N+1 SHALL return the written data (no extra stall).

Reset
REQ-031 On rst assertion, asynchronously: state = OWN_A, cnt = 0, response-pending flags = 0; a_rsp_valid = b_rsp_valid = 0.
REQ-032 A read accepted in the cycle before rst asserts SHALL produce no response; while rst = 1, both ready outputs and mem_cs SHALL be 0.

Configuration
REQ-033 With SRAM_ARB_BPRIO_EN defined, port B SHALL win whenever b_req_valid = 1 (strict priority, MAX_BURST ignored, cnt unused); without it, REQ-024..027 round-robin-burst SHALL apply.

Verification
REQ-034 Reset, A reads addr 0x010 (pre-loaded 0xBEEF) -> a_req_ready=1, mem_cs=1, mem_rd_addr=0x010; next cycle a_rsp_valid=1, a_rsp_data=0xBEEF.
REQ-035 B writes 0xA5A5 @0x3FF, next cycle B reads 0x3FF -> mem_we=1 then 0; b_rsp_valid=1 with 0xA5A5 two cycles after write; no rsp after write.
REQ-036 Both valid continuously, MAX_BURST=4 -> grants AAAABBBBAAAA...; single-valid port granted every cycle.
REQ-037 Read accepted cycle N, rst pulsed in N+1 -> no rsp_valid, state OWN_A after release.
REQ-038 SRAM_ARB_BPRIO_EN defined, both valid 10 cycles -> B granted all 10, A granted first cycle B drops valid.
